param_banked_ioiq: RTL and testbench

//  Parametrised N-bank in-order issue queue between rename and the memory/int issue pipes.

---
 rtl/param_banked_ioiq.sv | 141 ++++++++++++++
 tb/tb_param_banked_ioiq.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/param_banked_ioiq.sv
// param_banked_ioiq: N-bank in-order issue queue with writeback wakeup, enqueue bypass and partial recall.
// Optional per-bank head-blocked cycle counters on perf_blk when IOIQ_PERF_CNT_EN is defined.
module param_banked_ioiq #(
    parameter int NUM_BANKS = 2,
    parameter int DEPTH     = 8,
    parameter int NUM_WB    = 4,
    parameter int TAG_W     = 6,
    parameter int AL_W      = 5,
    parameter int PAY_W     = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ext_stall,
    input  logic [NUM_BANKS-1:0]       in_valid,
    input  logic [NUM_BANKS*TAG_W-1:0] in_rs1,
    input  logic [NUM_BANKS*TAG_W-1:0] in_rs2,
    input  logic [NUM_BANKS-1:0]       in_rdy1,
    input  logic [NUM_BANKS-1:0]       in_rdy2,
    input  logic [NUM_BANKS*AL_W-1:0]  in_al,
    input  logic [NUM_BANKS*PAY_W-1:0] in_pay,
    input  logic [NUM_WB-1:0]          wb_valid,
    input  logic [NUM_WB*TAG_W-1:0]    wb_tag,
    input  logic                       if_recall,
    input  logic [AL_W-1:0]            recall_al,
    input  logic [AL_W-1:0]            al_oldest,
    output logic [NUM_BANKS-1:0]       out_valid,
    output logic [NUM_BANKS*PAY_W-1:0] out_pay,
    output logic [NUM_BANKS*AL_W-1:0]  out_al,
`ifdef IOIQ_PERF_CNT_EN
    output logic [NUM_BANKS*32-1:0]    perf_blk,
`endif
    output logic                       int_stall
);
    localparam int IW    = $clog2(DEPTH);
    localparam int PTR_W = IW + 1;

    logic [NUM_BANKS-1:0] w_full;
    logic [AL_W-1:0]      w_recall_age;

    function automatic logic wb_hit(input logic [TAG_W-1:0] t);
        logic h;
        h = 1'b0;
        for (int k = 0; k < NUM_WB; k++)
            h = h | (wb_valid[k] && (wb_tag[k*TAG_W +: TAG_W] == t));
        return h;
    endfunction

    function automatic logic [AL_W-1:0] age(input logic [AL_W-1:0] x);
        return x - al_oldest;
    endfunction

    assign w_recall_age = age(recall_al);
    assign int_stall    = ext_stall | (|w_full);

    genvar b;
    generate
        for (b = 0; b < NUM_BANKS; b++) begin : g_bank
            logic [DEPTH-1:0] r_v, r_rdy1, r_rdy2;
            logic [TAG_W-1:0] r_rs1 [DEPTH];
            logic [TAG_W-1:0] r_rs2 [DEPTH];
            logic [AL_W-1:0]  r_al  [DEPTH];
            logic [PAY_W-1:0] r_pay [DEPTH];
            logic [PTR_W-1:0] r_head, r_tail;
            logic [IW-1:0]    w_hidx, w_tidx;
            logic             w_hv, w_hrdy, w_enq, w_brdy1, w_brdy2;
            logic [DEPTH-1:0] w_keep;
            logic [PTR_W-1:0] w_cnt;

            assign w_hidx    = r_head[IW-1:0];
            assign w_tidx    = r_tail[IW-1:0];
            assign w_full[b] = (w_hidx == w_tidx) && (r_head[IW] != r_tail[IW]);
            assign w_hv      = r_v[w_hidx];
            assign w_hrdy    = r_rdy1[w_hidx] & r_rdy2[w_hidx];
            assign w_enq     = in_valid[b] & !int_stall & !if_recall;
            assign w_brdy1   = in_rdy1[b] | wb_hit(in_rs1[b*TAG_W +: TAG_W]);
            assign w_brdy2   = in_rdy2[b] | wb_hit(in_rs2[b*TAG_W +: TAG_W]);

            assign out_valid[b]              = w_hv & w_hrdy & !ext_stall & !if_recall;
            assign out_pay[b*PAY_W +: PAY_W] = r_pay[w_hidx];
            assign out_al[b*AL_W +: AL_W]    = r_al[w_hidx];

            // Survivors of a recall are exactly the valid entries no younger than the branch.
            always_comb begin
                w_keep = '0;
                w_cnt  = '0;
                for (int d = 0; d < DEPTH; d++) begin
                    w_keep[d] = r_v[d] & (age(r_al[d]) <= w_recall_age);
                    w_cnt     = w_cnt + PTR_W'(w_keep[d]);
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_v    <= '0;
                    r_rdy1 <= '0;
                    r_rdy2 <= '0;
                    r_head <= '0;
                    r_tail <= '0;
                end else begin
                    for (int d = 0; d < DEPTH; d++) begin
                        if (wb_hit(r_rs1[d])) r_rdy1[d] <= 1'b1;
                        if (wb_hit(r_rs2[d])) r_rdy2[d] <= 1'b1;
                    end
                    if (if_recall) begin
                        r_v    <= w_keep;
                        r_tail <= r_head + w_cnt;
                    end else begin
                        if (out_valid[b]) begin
                            r_v[w_hidx] <= 1'b0;
                            r_head      <= r_head + 1'b1;
                        end
                        if (w_enq) begin
                            r_v[w_tidx]    <= 1'b1;
                            r_rdy1[w_tidx] <= w_brdy1;
                            r_rdy2[w_tidx] <= w_brdy2;
                            r_tail         <= r_tail + 1'b1;
                        end
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (w_enq) begin
                    r_rs1[w_tidx] <= in_rs1[b*TAG_W +: TAG_W];
                    r_rs2[w_tidx] <= in_rs2[b*TAG_W +: TAG_W];
                    r_al[w_tidx]  <= in_al[b*AL_W +: AL_W];
                    r_pay[w_tidx] <= in_pay[b*PAY_W +: PAY_W];
                end
            end

`ifdef IOIQ_PERF_CNT_EN
            logic [31:0] r_perf;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) r_perf <= '0;
                else if (w_hv && !w_hrdy && (r_perf != 32'hFFFF_FFFF)) r_perf <= r_perf + 1'b1;
            end
            assign perf_blk[b*32 +: 32] = r_perf;
`endif
        end
    endgenerate
endmodule

// File: tb/tb_param_banked_ioiq.sv
// tb_param_banked_ioiq: random stimulus against a queue-level reference model with a decoupled scoreboard monitor.
module tb_param_banked_ioiq;
    localparam int NB = 2, D = 8, NW = 4, TW = 6, AW = 5, PW = 64, NCYC = 3000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ext_stall = 1'b0, if_recall = 1'b0;
    logic [NB-1:0] in_valid = '0, in_rdy1 = '0, in_rdy2 = '0, out_valid;
    logic [NB*TW-1:0] in_rs1 = '0, in_rs2 = '0;
    logic [NB*AW-1:0] in_al = '0, out_al;
    logic [NB*PW-1:0] in_pay = '0, out_pay;
    logic [NW-1:0] wb_valid = '0;
    logic [NW*TW-1:0] wb_tag = '0;
    logic [AW-1:0] recall_al = '0, al_oldest = '0;
    logic int_stall;
`ifdef IOIQ_PERF_CNT_EN
    logic [NB*32-1:0] perf_blk;
`endif

    always #5 clk = ~clk;

    param_banked_ioiq dut (
        .clk(clk), .reset(reset), .ext_stall(ext_stall), .in_valid(in_valid),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rdy1(in_rdy1), .in_rdy2(in_rdy2),
        .in_al(in_al), .in_pay(in_pay), .wb_valid(wb_valid), .wb_tag(wb_tag),
        .if_recall(if_recall), .recall_al(recall_al), .al_oldest(al_oldest),
        .out_valid(out_valid), .out_pay(out_pay), .out_al(out_al),
`ifdef IOIQ_PERF_CNT_EN
        .perf_blk(perf_blk),
`endif
        .int_stall(int_stall)
    );

    typedef struct { logic [TW-1:0] rs1, rs2; bit r1, r2; int seq; } ent_t;
    typedef struct { logic [AW-1:0] al; logic [PW-1:0] pay; } sb_t;
    typedef struct { logic [NB-1:0] ov; logic st; } ctl_t;

    ent_t mq [NB][$];
    sb_t  sbq[NB][$];
    ctl_t cq[$];
    int checks = 0, failures = 0;

    function automatic bit hit(input logic [TW-1:0] t);
        for (int k = 0; k < NW; k++)
            if (wb_valid[k] && wb_tag[k*TW +: TW] == t) return 1'b1;
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        ctl_t c;
        sb_t s;
        if (cq.size() != 0) begin
            c = cq.pop_front();
            checks++;
            if (out_valid !== c.ov) begin
                failures++;
                $display("FAIL out_valid t=%0t got=%b exp=%b", $time, out_valid, c.ov);
            end
            checks++;
            if (int_stall !== c.st) begin
                failures++;
                $display("FAIL int_stall t=%0t got=%b exp=%b", $time, int_stall, c.st);
            end
            for (int b = 0; b < NB; b++) begin
                if (out_valid[b]) begin
                    checks++;
                    if (sbq[b].size() == 0) begin
                        failures++;
                        $display("FAIL issue_empty bank=%0d t=%0t got=issue exp=none", b, $time);
                    end else begin
                        s = sbq[b].pop_front();
                        if (out_al[b*AW +: AW] !== s.al || out_pay[b*PW +: PW] !== s.pay) begin
                            failures++;
                            $display("FAIL issue_data bank=%0d t=%0t got al=%0d pay=%h exp al=%0d pay=%h",
                                     b, $time, out_al[b*AW +: AW], out_pay[b*PW +: PW], s.al, s.pay);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int next_seq, oldest, rseq, idx, cnt;
        bit anyfull, ist, lowwb;
        ctl_t c;
        ent_t e;
        next_seq = 0;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            #1;
            reset     = (cyc < 3) || (cyc >= 1500 && cyc < 1503);
            lowwb     = ((cyc / 300) % 2) == 1;
            ext_stall = ($urandom % 10) == 0;
            if_recall = ($urandom % 25) == 0;
            for (int k = 0; k < NW; k++) begin
                wb_valid[k]        = lowwb ? (($urandom % 25) == 0) : ($urandom % 2);
                wb_tag[k*TW +: TW] = TW'($urandom % 16);
            end
            oldest = next_seq;
            for (int b = 0; b < NB; b++)
                if (mq[b].size() != 0 && mq[b][0].seq < oldest) oldest = mq[b][0].seq;
            al_oldest = AW'(oldest);
            rseq      = oldest + int'($urandom_range(0, next_seq - oldest));
            recall_al = AW'(rseq);
            idx = 0;
            for (int b = 0; b < NB; b++) begin
                in_valid[b]          = (($urandom % 4) != 0) && (next_seq - oldest < 24);
                in_rs1[b*TW +: TW]   = TW'($urandom % 16);
                in_rs2[b*TW +: TW]   = TW'($urandom % 16);
                in_rdy1[b]           = $urandom % 2;
                in_rdy2[b]           = $urandom % 2;
                in_al[b*AW +: AW]    = AW'(next_seq + idx);
                in_pay[b*PW +: PW]   = {$urandom, $urandom};
                if (in_valid[b]) idx++;
            end
            if (reset) begin
                for (int b = 0; b < NB; b++) begin
                    mq[b].delete();
                    sbq[b].delete();
                end
                c.ov = '0;
                c.st = ext_stall;
                cq.push_back(c);
                continue;
            end
            anyfull = 1'b0;
            for (int b = 0; b < NB; b++) if (mq[b].size() == D) anyfull = 1'b1;
            ist  = ext_stall | anyfull;
            c.st = ist;
            for (int b = 0; b < NB; b++)
                c.ov[b] = mq[b].size() != 0 && mq[b][0].r1 && mq[b][0].r2 && !ext_stall && !if_recall;
            cq.push_back(c);
            cnt = 0;
            for (int b = 0; b < NB; b++) begin
                for (int i = 0; i < mq[b].size(); i++) begin
                    if (hit(mq[b][i].rs1)) mq[b][i].r1 = 1'b1;
                    if (hit(mq[b][i].rs2)) mq[b][i].r2 = 1'b1;
                end
                if (if_recall) begin
                    while (mq[b].size() != 0 && mq[b][mq[b].size()-1].seq > rseq) begin
                        void'(mq[b].pop_back());
                        void'(sbq[b].pop_back());
                    end
                end else begin
                    if (c.ov[b]) void'(mq[b].pop_front());
                    if (in_valid[b] && !ist) begin
                        e.rs1 = in_rs1[b*TW +: TW];
                        e.rs2 = in_rs2[b*TW +: TW];
                        e.r1  = in_rdy1[b] | hit(e.rs1);
                        e.r2  = in_rdy2[b] | hit(e.rs2);
                        e.seq = next_seq + cnt;
                        mq[b].push_back(e);
                        sbq[b].push_back('{AW'(e.seq), in_pay[b*PW +: PW]});
                        cnt++;
                    end
                end
            end
            next_seq += cnt;
        end
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
